// File: rtl/score_to_digits.sv
`default_nettype none
// ============================================================================
// Module  : score_to_digits
// Brief   : Sequential double-dabble binary-to-2-digit converter for a 7-seg scanner.
// Revision: 1.0 - initial release
// ============================================================================
module score_to_digits #(
    parameter int         WIDTH      = 7,
    parameter int         MAX_VAL    = 99,
    parameter logic [4:0] BLANK_CODE = 5'd16,
    parameter logic [4:0] DASH_CODE  = 5'd17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic [4:0]       d_tens,
    output logic [4:0]       d_ones
);

    localparam int             c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_val;
    logic             r_blank;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [c_CW-1:0]  r_cnt;
    logic             r_done;
    logic [4:0]       r_d_tens;
    logic [4:0]       r_d_ones;

    logic [3:0]       w_tens_adj;
    logic [3:0]       w_ones_adj;
    logic             w_ovf;

    assign w_tens_adj = (r_tens >= 4'd5) ? r_tens + 4'd3 : r_tens;
    assign w_ones_adj = (r_ones >= 4'd5) ? r_ones + 4'd3 : r_ones;
    // Overflow uses the copy latched at start, never the live input.
    assign w_ovf      = (32'(r_val) > 32'(MAX_VAL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CONV;
            S_CONV:   if (r_cnt == c_LAST) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift  <= '0;
            r_val    <= '0;
            r_blank  <= 1'b0;
            r_tens   <= 4'd0;
            r_ones   <= 4'd0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_d_tens <= BLANK_CODE;
            r_d_ones <= BLANK_CODE;
        end else begin
            r_done <= (r_state == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift <= value;
                        r_val   <= value;
                        r_blank <= blank_lz;
                        r_tens  <= 4'd0;
                        r_ones  <= 4'd0;
                        r_cnt   <= '0;
                    end
                end
                S_CONV: begin
                    // The bit leaving the tens nibble would be hundreds; it is dropped.
                    r_tens  <= {w_tens_adj[2:0], w_ones_adj[3]};
                    r_ones  <= {w_ones_adj[2:0], r_shift[WIDTH-1]};
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                end
                S_FINISH: begin
                    if (w_ovf) begin
                        r_d_tens <= DASH_CODE;
                        r_d_ones <= DASH_CODE;
                    end else begin
                        r_d_ones <= {1'b0, r_ones};
                        r_d_tens <= ((r_tens == 4'd0) && r_blank) ? BLANK_CODE : {1'b0, r_tens};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign d_tens = r_d_tens;
    assign d_ones = r_d_ones;

endmodule
`default_nettype wire

// File: tb/tb_score_to_digits.sv
`default_nettype none
// ============================================================================
// Module  : tb_score_to_digits
// Brief   : Self-checking bench for score_to_digits against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_score_to_digits;

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] value;
    logic       blank_lz;
    logic       busy;
    logic       done;
    logic [4:0] d_tens;
    logic [4:0] d_ones;

    int n_vec;
    int n_err;

    score_to_digits #(
        .WIDTH(7), .MAX_VAL(99), .BLANK_CODE(5'd16), .DASH_CODE(5'd17)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .value   (value),
        .blank_lz(blank_lz),
        .busy    (busy),
        .done    (done),
        .d_tens  (d_tens),
        .d_ones  (d_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain decimal arithmetic with blanking / overflow rules.
    function automatic int exp_tens(input int v, input logic b);
        if (v > 99) return 17;
        if ((v / 10) == 0 && b) return 16;
        return v / 10;
    endfunction

    function automatic int exp_ones(input int v);
        if (v > 99) return 17;
        return v % 10;
    endfunction

    task automatic convert(input int v, input logic b, input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        start = 1'b1; value = 7'(v); blank_lz = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        if (busy) bcnt++;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        check({tag, " latency"}, lat, 8);
        check({tag, " busy cycles"}, bcnt, 8);
        check({tag, " tens"}, int'(d_tens), exp_tens(v, b));
        check({tag, " ones"}, int'(d_ones), exp_ones(v));
        @(posedge clk); #1;
        check({tag, " done width"}, int'(done), 0);
    endtask

    initial begin
        int seen;
        int t_done [2];
        int r_t [2];
        int r_o [2];
        int v;
        logic b;

        n_vec = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; value = '0; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        check("reset tens", int'(d_tens), 16);
        check("reset ones", int'(d_ones), 16);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done || busy) seen++; end
        check("idle no activity", seen, 0);

        convert(42, 1'b0, "v42");
        repeat (5) @(posedge clk); #1;
        check("hold tens", int'(d_tens), 4);
        check("hold ones", int'(d_ones), 2);

        convert(7,  1'b1, "v7 blank");
        convert(7,  1'b0, "v7");
        convert(0,  1'b1, "v0 blank");
        convert(99, 1'b0, "v99");
        convert(10, 1'b1, "v10 blank");
        convert(100, 1'b0, "v100");
        convert(127, 1'b1, "v127");

        for (int i = 0; i < 128; i++) begin
            convert(i, 1'b0, $sformatf("sweep%0d", i));
            convert(i, 1'b1, $sformatf("sweepb%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 127));
            b = 1'($urandom);
            convert(v, b, $sformatf("rand%0d", v));
        end

        // start pulses while busy are ignored
        @(negedge clk);
        start = 1'b1; value = 7'd42; blank_lz = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0; t_done[0] = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 5); value = 7'd55;
            @(posedge clk); #1;
            if (done) begin
                if (seen == 0) begin t_done[0] = k; r_t[0] = d_tens; r_o[0] = d_ones; end
                seen++;
            end
        end
        start = 1'b0;
        check("ignore done count", seen, 1);
        check("ignore done edge", t_done[0], 8);
        check("ignore tens", r_t[0], 4);
        check("ignore ones", r_o[0], 2);

        // back-to-back with start held
        @(negedge clk);
        start = 1'b1; value = 7'd12; blank_lz = 1'b0;
        @(posedge clk); #1;
        value = 7'd34;
        seen = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 9) start = 1'b0;
            if (done) begin
                if (seen < 2) begin t_done[seen] = k; r_t[seen] = d_tens; r_o[seen] = d_ones; end
                seen++;
            end
        end
        check("b2b done count", seen, 2);
        if (seen >= 2) begin
            check("b2b first edge", t_done[0], 8);
            check("b2b period", t_done[1] - t_done[0], 9);
            check("b2b r1 tens", r_t[0], 1);
            check("b2b r1 ones", r_o[0], 2);
            check("b2b r2 tens", r_t[1], 3);
            check("b2b r2 ones", r_o[1], 4);
        end

        // async reset mid-conversion
        @(negedge clk);
        start = 1'b1; value = 7'd88; blank_lz = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort tens", int'(d_tens), 16);
        check("abort ones", int'(d_ones), 16);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done) seen++; end
        check("abort no done", seen, 0);
        convert(88, 1'b0, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
